// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer scan reader.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

  localparam int FB_WIDTH  = 255;
  localparam int FB_HEIGHT = 255;
  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 8;

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry first-word-fall-through FIFO carrying a pixel plus its eol/last tags.
module fb_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_eol,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_eol,
  output logic              head_last,
  output logic [1:0]        count,
  output logic              valid
);

  logic [DATA_W+1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != 2'd0);
  assign do_pop  = pop & valid;
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_push = push & ((count != 2'd2) | do_pop);

  assign {head_last, head_eol, head_data} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_last, push_eol, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer read controller: raster-scans the RAM into a valid/ready pixel
// stream while giving game-logic writes priority on the single RAM port.
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_eol,
  output logic              pix_last,
  output logic [1:0]        dbg_state
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  fb_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              inflight;
  logic              inflight_eol;
  logic              inflight_last;

  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic              head_eol;
  logic              head_last;

  logic              wr_grant;
  logic              pop;
  logic [2:0]        credit_used;
  logic              rd_issue;
  logic              is_eol;
  logic              is_last;

  assign wr_grant    = wr_req & rst_n;
  assign pop         = pix_valid & pix_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight};
  // A read may issue only if its data is guaranteed a FIFO slot when it returns.
  assign rd_issue    = (state == SCAN) & ~wr_req & (credit_used < (3'd2 + {2'b00, pop}));
  assign is_eol      = (x == X_LAST);
  assign is_last     = is_eol & (y == Y_LAST);

  assign pix_valid = fifo_valid;
  assign pix_eol   = fifo_valid & head_eol;
  assign pix_last  = fifo_valid & head_last;
  assign dbg_state = state;

  always_comb begin
    ram_a  = '0;
    ram_d  = '0;
    ram_we = 1'b0;
    wr_ack = 1'b0;
    if (wr_grant) begin
      ram_a  = wr_addr;
      ram_d  = wr_data;
      ram_we = 1'b1;
      wr_ack = 1'b1;
    end else if (rd_issue) begin
      ram_a = addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      addr          <= '0;
      x             <= '0;
      y             <= '0;
      inflight      <= 1'b0;
      inflight_eol  <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_eol  <= rd_issue & is_eol;
      inflight_last <= rd_issue & is_last;
      case (state)
        IDLE: begin
          if (frame_start) begin
            addr  <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (rd_issue) begin
            // Counters freeze on the final pixel rather than wrap past the frame.
            if (is_last) begin
              state <= DRAIN;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (is_eol) begin
                x <= '0;
                y <= y + YW'(1);
              end else begin
                x <= x + XW'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (pop & pix_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fb_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_q),
    .push_eol  (inflight_eol),
    .push_last (inflight_last),
    .pop       (pop),
    .head_data (pix_data),
    .head_eol  (head_eol),
    .head_last (head_last),
    .count     (fifo_count),
    .valid     (fifo_valid)
  );

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench: a 4x3 instance for latency, backpressure, write arbitration and
// reset abort, plus a default-size instance for a deep idle write.
module tb_fb_scan_reader;
  import fb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic load_mem;

  // ---------------- small instance (4x3) ----------------
  logic        frame_start, wr_req, wr_ack, ram_we, pix_valid, pix_ready, pix_eol, pix_last, busy;
  logic [15:0] wr_addr, ram_a;
  logic [7:0]  wr_data, ram_d, ram_q, pix_data;
  logic [1:0]  dbg_state;

  fb_scan_reader #(.WIDTH(4), .HEIGHT(3), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_last(pix_last), .dbg_state(dbg_state)
  );

  // ---------------- default-size instance ----------------
  logic        b_frame_start, b_wr_req, b_wr_ack, b_ram_we, b_pix_valid, b_pix_ready, b_pix_eol, b_pix_last, b_busy;
  logic [15:0] b_wr_addr, b_ram_a;
  logic [7:0]  b_wr_data, b_ram_d, b_ram_q, b_pix_data;
  logic [1:0]  b_dbg_state;

  fb_scan_reader dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(b_frame_start), .busy(b_busy),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ack(b_wr_ack),
    .ram_a(b_ram_a), .ram_d(b_ram_d), .ram_we(b_ram_we), .ram_q(b_ram_q),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_data(b_pix_data),
    .pix_eol(b_pix_eol), .pix_last(b_pix_last), .dbg_state(b_dbg_state)
  );

  // ---------------- RAM models: registered read, mem[i] = i ----------------
  logic [7:0] mem_a [65536];
  logic [7:0] mem_b [65536];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 65536; i++) mem_a[i] <= 8'(i);
    end else begin
      if (ram_we) mem_a[ram_a] <= ram_d;
      ram_q <= mem_a[ram_a];
    end
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 65536; i++) mem_b[i] <= 8'(i);
    end else begin
      if (b_ram_we) mem_b[b_ram_a] <= b_ram_d;
      b_ram_q <= mem_b[b_ram_a];
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];  // {last, eol, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic void fill_exp(input bit aa_at5);
    exp_q.delete();
    for (int i = 0; i < 12; i++)
      exp_q.push_back({(i == 11), (i % 4 == 3), ((aa_at5 && i == 5) ? 8'hAA : 8'(i))});
  endfunction

  // One 4x3 frame: frame_start at c=0, optional second pulse, optional write of 0xAA to 5.
  task automatic run_frame(input string tag, input bit toggle, input int wr_cyc,
                           input int restart_cyc, input int exp_last_cyc);
    int c = 0;
    int got = 0;
    bit done = 0;
    bit held = 0;
    bit last_seen = 0;
    logic [9:0] held_v = '0;
    while (!done && c < 200) begin
      @(posedge clk); #1;
      frame_start = (c == 0) || (c == restart_cyc);
      pix_ready   = toggle ? (c % 2 == 0) : 1'b1;
      wr_req      = (c == wr_cyc);
      wr_addr     = 16'd5;
      wr_data     = 8'hAA;
      @(negedge clk);
      if (c == wr_cyc) begin
        check({tag, " wr_ack"}, wr_ack, 1);
        check({tag, " wr ram_we"}, ram_we, 1);
        check({tag, " wr ram_a"}, ram_a, 5);
        check({tag, " wr ram_d"}, ram_d, 8'hAA);
      end
      if (last_seen) begin
        check({tag, " busy fall"}, busy, 0);
        done = 1;
      end else begin
        if (held) begin
          check({tag, " stall stable"}, {pix_valid, pix_last, pix_eol, pix_data}, {1'b1, held_v});
          held = 0;
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) check({tag, " extra pixel"}, pix_data, 8'hxx);
          else check($sformatf("%s pix%0d", tag, got), {pix_last, pix_eol, pix_data}, exp_q.pop_front());
          got++;
          if (pix_last) begin
            check({tag, " busy at last"}, busy, 1);
            if (exp_last_cyc >= 0) check({tag, " last cycle"}, c, exp_last_cyc);
            last_seen = 1;
          end
        end else if (pix_valid) begin
          held   = 1;
          held_v = {pix_last, pix_eol, pix_data};
        end
      end
      c++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " count"}, got, 12);
    frame_start = 0;
    wr_req      = 0;
  endtask

  typedef struct {
    logic        fs;
    logic [1:0]  st;
    logic        busy;
    logic        valid;
    logic [7:0]  data;
    logic        eol;
    logic        last;
    logic [15:0] ra;
  } vec_t;

  vec_t vecs[17];

  initial begin
    rst_n = 1; load_mem = 1;
    frame_start = 0; wr_req = 0; wr_addr = 0; wr_data = 0; pix_ready = 1;
    b_frame_start = 0; b_wr_req = 0; b_wr_addr = 0; b_wr_data = 0; b_pix_ready = 1;
    #2 rst_n = 0;
    @(posedge clk); #1 load_mem = 0;
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst valid", pix_valid, 0);
    check("rst data", pix_data, 0);
    check("rst eol/last", {pix_eol, pix_last}, 0);
    check("rst ram_a", ram_a, 0);
    check("rst ram_d", ram_d, 0);
    check("rst we/ack", {ram_we, wr_ack}, 0);
    check("rst state", dbg_state, IDLE);
    rst_n = 1;

    // Basic frame, cycle-accurate table.
    for (int c = 0; c < 17; c++) begin
      vecs[c].fs    = (c == 0);
      vecs[c].st    = (c == 0 || c >= 15) ? IDLE : ((c <= 12) ? SCAN : DRAIN);
      vecs[c].busy  = (c >= 1 && c <= 14);
      vecs[c].valid = (c >= 3 && c <= 14);
      vecs[c].data  = 8'(c - 3);
      vecs[c].eol   = vecs[c].valid && ((c - 3) % 4 == 3);
      vecs[c].last  = (c == 14);
      vecs[c].ra    = (c >= 1 && c <= 12) ? 16'(c - 1) : 16'd0;
    end
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      frame_start = vecs[c].fs;
      pix_ready   = 1;
      @(negedge clk);
      check($sformatf("t1[%0d] state", c), dbg_state, vecs[c].st);
      check($sformatf("t1[%0d] busy", c), busy, vecs[c].busy);
      check($sformatf("t1[%0d] valid", c), pix_valid, vecs[c].valid);
      if (vecs[c].valid) check($sformatf("t1[%0d] data", c), pix_data, vecs[c].data);
      check($sformatf("t1[%0d] eol", c), pix_eol, vecs[c].eol);
      check($sformatf("t1[%0d] last", c), pix_last, vecs[c].last);
      check($sformatf("t1[%0d] ram_a", c), ram_a, vecs[c].ra);
      check($sformatf("t1[%0d] ram_we", c), ram_we, 0);
    end
    frame_start = 0;

    // Backpressure: ready toggles 1,0,1,0.
    fill_exp(0);
    run_frame("t2", 1, -1, -1, -1);

    // Write at cycle 4 steals one read slot; address 5 not yet read, so 0xAA shows now.
    fill_exp(1);
    run_frame("t3", 0, 4, -1, 15);
    fill_exp(1);
    run_frame("t3b", 0, -1, -1, 14);

    // Second frame_start mid-scan is ignored.
    fill_exp(1);
    run_frame("t4", 0, -1, 6, 14);

    // Reset mid-scan at pixel 6.
    begin
      bit found = 0;
      bit any_out = 0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(posedge clk); #1;
        frame_start = (c == 0);
        pix_ready   = 1;
        @(negedge clk);
        if (pix_valid && pix_data == 8'd6) found = 1;
      end
      check("t5 reached pix6", found, 1);
      frame_start = 0;
      #1 rst_n = 0;
      #1;
      check("t5 async busy", busy, 0);
      check("t5 async valid", pix_valid, 0);
      check("t5 async data", pix_data, 0);
      check("t5 async eol/last", {pix_eol, pix_last}, 0);
      check("t5 async ram", {ram_a, ram_we, wr_ack}, 0);
      check("t5 async state", dbg_state, IDLE);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (pix_valid || busy || ram_a != 16'd0) any_out = 1;
      end
      check("t5 quiet after reset", any_out, 0);
      fill_exp(1);
      run_frame("t5 recover", 0, -1, -1, 14);
    end

    // Default 255x255: idle write then scan to pixel 0x1234.
    begin
      int idx = 0;
      bit found = 0;
      @(posedge clk); #1;
      b_wr_req = 1; b_wr_addr = 16'h1234; b_wr_data = 8'h55;
      @(negedge clk);
      check("t6 idle wr_ack", b_wr_ack, 1);
      check("t6 idle ram_we", b_ram_we, 1);
      check("t6 idle ram_a", b_ram_a, 16'h1234);
      check("t6 idle ram_d", b_ram_d, 8'h55);
      @(posedge clk); #1;
      b_wr_req = 0; b_frame_start = 1;
      @(posedge clk); #1;
      b_frame_start = 0;
      for (int c = 0; c < 6000 && !found; c++) begin
        @(negedge clk);
        if (b_pix_valid && b_pix_ready) begin
          if (idx == 254) check("t6 eol x254", {b_pix_eol, b_pix_data}, {1'b1, 8'hFE});
          if (idx == 255) check("t6 row1 start", {b_pix_eol, b_pix_data}, {1'b0, 8'hFF});
          if (idx == 16'h1234) begin
            check("t6 pix 0x1234", {b_pix_last, b_pix_eol, b_pix_data}, {2'b00, 8'h55});
            found = 1;
          end
          idx++;
        end
      end
      check("t6 reached 0x1234", found, 1);
      check("t6 busy mid-frame", b_busy, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_scan_reader.md
# fb_scan_reader

Read-side controller for the single-port 8-bit board frame-buffer RAM. Owns the RAM's `a`/`d`/`we` pins and consumes its registered `q`. It arbitrates game-logic pixel writes against a raster scan that streams the whole frame, in row-major order, to the VGA pixel path over a valid/ready interface, with full backpressure support.

## Interface
- `WIDTH`, default 255: pixels per line.
- `HEIGHT`, default 255: lines per frame.
- `ADDR_W`, default 16: RAM address width. The block requires WIDTH*HEIGHT ≤ 2^ADDR_W.
- `DATA_W`, default 8: pixel width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_start`  in  1  one-cycle pulse that starts a frame scan.
- `busy`  out  1  high from the scan start until the last pixel is accepted.
- `wr_req`  in  1  game-logic write request, held until acked.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `wr_ack`  out  1  one-cycle pulse in the cycle the write drives the RAM.
- `ram_a`  out  ADDR_W  RAM address.
- `ram_d`  out  DATA_W  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_q`  in  DATA_W  RAM registered read data, valid 1 cycle after its address.
- `pix_valid`  out  1  output pixel valid.
- `pix_ready`  in  1  downstream accepts the pixel.
- `pix_data`  out  DATA_W  pixel value.
- `pix_eol`  out  1  current pixel is x = WIDTH-1.
- `pix_last`  out  1  current pixel is the last pixel of the frame.

## Operation
- FSM states:
  - IDLE: on `frame_start`, clear the linear address, x and y, then go to SCAN.
  - SCAN: issue reads. When address WIDTH*HEIGHT-1 is issued, go to DRAIN.
  - DRAIN: when `pix_last` is accepted (`pix_valid & pix_ready & pix_last`), go to IDLE.
- `frame_start` is ignored outside IDLE.
- Read issue in SCAN requires (fifo_count + inflight − pop) < 2, where pop = `pix_valid & pix_ready`, and no write is granted that cycle.
- Each issued read drives `ram_a` = the linear address with `ram_we` = 0. Then:
  - the address increments;
  - x increments and wraps to 0 at WIDTH-1, and y increments on that wrap;
  - inflight is set for one cycle;
  - on the next cycle `ram_q`, tagged with its eol/last flags, is pushed into the 2-entry FIFO.
- Writes have priority in every state. When `wr_req` is high, in that cycle:
  - `ram_a` = `wr_addr`, `ram_d` = `wr_data`, `ram_we` = 1;
  - `wr_ack` = 1;
  - no read is issued.
- A write to an address already read this frame is not reflected until the next frame.
- Output FIFO: 2 entries, first-word-fall-through. `pix_*` come from the head entry.
- When idle, the block drives `ram_a` = 0 and `ram_we` = 0.
- Arithmetic: the address counter is ADDR_W bits, x is clog2(WIDTH) bits, y is clog2(HEIGHT) bits. None of them wraps past the frame end.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `wr_ack`, `ram_we`, `pix_valid`, `pix_eol`, `pix_last` = 0;
  - `ram_a`, `ram_d`, `pix_data` = 0;
  - FIFO empty, inflight = 0.
- Reset mid-scan aborts immediately. No residual pixels appear after reset is released.
- Latency:
  - `frame_start` at cycle 0 → SCAN and `busy` = 1 at cycle 1, with the first read issued in cycle 1;
  - FIFO push at the end of cycle 2;
  - `pix_valid` = 1 in cycle 3.
- Throughput is 1 pixel/cycle when `pix_ready` is held high and no writes occur. Each granted write costs exactly one read slot.
- Backpressure: while `pix_valid & !pix_ready`, `pix_data`/`pix_eol`/`pix_last` stay stable and no FIFO overflow is possible.
- `busy` falls in the cycle after `pix_last` is accepted.
- `wr_req` and read eligibility in the same cycle: the write wins and the read retries on the next cycle.
- `pix_ready` → `ram_a`/`ram_we` is a permitted combinational path.

## Structure
- Package `fb_pkg` holds:
  - `fb_state_t` (IDLE, SCAN, DRAIN);
  - default constants FB_WIDTH = 255, FB_HEIGHT = 255, FB_ADDR_W = 16, FB_DATA_W = 8.
- Sub-module `fb_skid_fifo`: 2-entry FWFT FIFO of {data, eol, last} with push, pop, count[1:0], valid.
- The top holds the FSM, counters, arbitration and credit check.

## Test plan
- WIDTH=4, HEIGHT=3, RAM preloaded mem[i]=i, `pix_ready`=1, pulse `frame_start` → 12 consecutive pixels 0..11 starting 3 cycles after the pulse; `pix_eol` on pixels 3, 7 and 11; `pix_last` on pixel 11 only; `busy` falls one cycle later.
- Same setup with `pix_ready` toggling 1,0,1,0 → pixels 0..11 in order with no duplicates or drops, and data stable while stalled.
- `wr_req` with addr=5, data=0xAA held during the scan at cycle 4 → `wr_ack` in cycle 4 with `ram_we`=1 and `ram_a`=5; the scan completes 1 cycle later; the next frame shows 0xAA at pixel 5.
- `frame_start` pulsed again mid-scan → ignored; exactly 12 pixels are produced.
- `rst_n` asserted at pixel 6 → all outputs are 0 asynchronously; after release, no pixels until a new `frame_start`.
- Idle write with addr=0x1234, data=0x55 → `wr_ack` the same cycle; a subsequent scan with WIDTH=255, HEIGHT=255 returns 0x55 at linear pixel 0x1234.
